// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared encodings for the instruction/data memory arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        I_BUSY = 2'b01,
        D_BUSY = 2'b10,
        DONE   = 2'b11
    } arb_state_e;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/imem_dmem_arbiter_starve_counter.sv
// Saturating count of consecutive data grants taken while fetch was waiting.
module arb_starve_counter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);
    localparam int CntW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    // Next count: clear wins over increment; increment stops at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != Limit)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit = (cnt_q == Limit);

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Arbiter sharing one single-ported memory between fetch and data ports.
// state  | meaning
// IDLE   | arbitrate; grant latches address/we/wdata
// I_BUSY | fetch access outstanding, wait for mem_ready
// D_BUSY | data access outstanding, wait for mem_ready
// DONE   | pulse owner's done, back to IDLE
module imem_dmem_arbiter
    import arb_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic [XLEN-1:0] if_rdata,
    output logic            if_done,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic [XLEN-1:0] d_rdata,
    output logic            d_done,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready,
    output logic            stall_f,
    output logic            stall_m
);
    localparam logic [XLEN-1:0] WordMask = ~XLEN'(3);

    arb_state_e      state_q, state_d;
    logic            owner_q, owner_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] if_rdata_q, if_rdata_d;
    logic [XLEN-1:0] d_rdata_q, d_rdata_d;
    logic            cnt_inc, cnt_clr, at_limit;

    arb_starve_counter #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk     (clk),
        .reset   (reset),
        .inc     (cnt_inc),
        .clr     (cnt_clr),
        .at_limit(at_limit)
    );

    // Arbitration, access sequencing and read-data capture.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        cnt_inc    = 1'b0;
        cnt_clr    = 1'b0;
        case (state_q)
            IDLE: begin
                if (d_req && !(if_req && at_limit)) begin
                    state_d = D_BUSY;
                    owner_d = OWN_D;
                    we_d    = d_we;
                    addr_d  = d_addr & WordMask;
                    wdata_d = d_wdata;
                    cnt_inc = if_req;
                    cnt_clr = !if_req;
                end else if (if_req) begin
                    state_d = I_BUSY;
                    owner_d = OWN_I;
                    we_d    = 1'b0;
                    addr_d  = if_addr & WordMask;
                    wdata_d = '0;
                    cnt_clr = 1'b1;
                end
            end
            I_BUSY: begin
                if (mem_ready) begin
                    if_rdata_d = mem_rdata;
                    state_d    = DONE;
                end
            end
            D_BUSY: begin
                if (mem_ready) begin
                    // Stores leave the load-data register untouched.
                    if (!we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            owner_q    <= OWN_I;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign mem_req   = (state_q == I_BUSY) || (state_q == D_BUSY);
    assign mem_we    = (state_q == D_BUSY) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_done   = (state_q == DONE) && (owner_q == OWN_I);
    assign d_done    = (state_q == DONE) && (owner_q == OWN_D);
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign stall_f   = if_req && !if_done;
    assign stall_m   = d_req && !d_done;

endmodule
